dmem_responder: RTL and testbench

- Multi-cycle data-memory responder. It serves the MEM-stage load/store requests issued by the pipelined CPU core.
- Accepts one request at a time over a req/ack handshake and holds the pipeline with stall_o until the access completes.
- Performs byte, half and word accesses with RISC-V load sign/zero extension.
- Flags misaligned and out-of-range accesses with err_o.

---
 rtl/dmem_responder_pkg.sv | 16 +
 rtl/dmem_load_align.sv | 26 ++
 rtl/dmem_responder.sv | 140 ++++++++++++++
 tb/tb_dmem_responder.sv | 248 ++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_responder_pkg.sv
// rtl/dmem_responder_pkg.sv - shared types and constants for the data-memory responder
package dmem_responder_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2
    } state_t;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    localparam int CNT_W = 4;

endpackage

// File: rtl/dmem_load_align.sv
// rtl/dmem_load_align.sv - selects the addressed byte/half of a word and sign/zero extends it
module dmem_load_align
    import dmem_responder_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  addr_lo,
    input  logic [1:0]  size,
    input  logic        is_unsigned,
    output logic [31:0] data
);

    logic [7:0]  byte_v;
    logic [15:0] half_v;

    always_comb begin
        byte_v = word[8*addr_lo +: 8];
        half_v = addr_lo[1] ? word[31:16] : word[15:0];
        data   = word;
        case (size)
            SIZE_B:  data = is_unsigned ? {24'd0, byte_v} : {{24{byte_v[7]}}, byte_v};
            SIZE_H:  data = is_unsigned ? {16'd0, half_v} : {{16{half_v[15]}}, half_v};
            default: data = word;
        endcase
    end

endmodule

// File: rtl/dmem_responder.sv
// rtl/dmem_responder.sv - multi-cycle load/store responder with req/ack handshake and pipeline stall
module dmem_responder
    import dmem_responder_pkg::*;
#(
    parameter int ADDR_W  = 10,
    parameter int LATENCY = 3
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_i,
    input  logic        we_i,
    input  logic [1:0]  size_i,
    input  logic        unsigned_i,
    input  logic [31:0] addr_i,
    input  logic [31:0] wdata_i,
    output logic        ack_o,
    output logic [31:0] rdata_o,
    output logic        err_o,
    output logic        stall_o
);

    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

    state_t             state;
    logic [CNT_W-1:0]   cnt;
    logic               we_q;
    logic               uns_q;
    logic               err_q;
    logic [1:0]         size_q;
    logic [ADDR_W+1:0]  addr_q;
    logic [31:0]        wdata_q;

    logic [31:0]        mem [0:(1<<ADDR_W)-1];

    logic               req_err;
    logic               do_access;
    logic [3:0]         lane_mask;
    logic [31:0]        lane_data;
    logic [31:0]        rd_word;
    logic [31:0]        load_val;

    // Error is decided at acceptance from the live operands, then carried with the request.
    always_comb begin
        req_err = (size_i == 2'd3)
               || (size_i == SIZE_H && addr_i[0])
               || (size_i == SIZE_W && addr_i[1:0] != 2'b00)
               || (addr_i[31:ADDR_W+2] != '0);
    end

    assign do_access = (state == ST_WAIT) && (cnt == '0);
    assign stall_o   = ((state == ST_IDLE) && req_i) || (state == ST_WAIT);
    assign rd_word   = mem[addr_q[ADDR_W+1:2]];

    // Store data is replicated across lanes so the mask alone selects what lands.
    always_comb begin
        lane_mask = 4'b0000;
        lane_data = wdata_q;
        case (size_q)
            SIZE_B: begin
                lane_mask = 4'b0001 << addr_q[1:0];
                lane_data = {4{wdata_q[7:0]}};
            end
            SIZE_H: begin
                lane_mask = addr_q[1] ? 4'b1100 : 4'b0011;
                lane_data = {2{wdata_q[15:0]}};
            end
            SIZE_W: lane_mask = 4'b1111;
            default: lane_mask = 4'b0000;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (do_access && we_q && !err_q) begin
            for (int b = 0; b < 4; b++) begin
                if (lane_mask[b]) begin
                    mem[addr_q[ADDR_W+1:2]][8*b +: 8] <= lane_data[8*b +: 8];
                end
            end
        end
    end

    dmem_load_align u_load_align (
        .word        (rd_word),
        .addr_lo     (addr_q[1:0]),
        .size        (size_q),
        .is_unsigned (uns_q),
        .data        (load_val)
    );

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state   <= ST_IDLE;
            cnt     <= '0;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            err_q   <= 1'b0;
            size_q  <= SIZE_B;
            addr_q  <= '0;
            wdata_q <= '0;
            ack_o   <= 1'b0;
            rdata_o <= '0;
            err_o   <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    ack_o   <= 1'b0;
                    rdata_o <= '0;
                    err_o   <= 1'b0;
                    if (req_i) begin
                        we_q    <= we_i;
                        uns_q   <= unsigned_i;
                        size_q  <= size_i;
                        addr_q  <= addr_i[ADDR_W+1:0];
                        wdata_q <= wdata_i;
                        err_q   <= req_err;
                        cnt     <= CNT_INIT;
                        state   <= ST_WAIT;
                    end
                end
                ST_WAIT: begin
                    if (cnt == '0) begin
                        state   <= ST_RESP;
                        ack_o   <= 1'b1;
                        err_o   <= err_q;
                        rdata_o <= (!we_q && !err_q) ? load_val : '0;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                default: begin
                    state   <= ST_IDLE;
                    ack_o   <= 1'b0;
                    rdata_o <= '0;
                    err_o   <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_responder.sv
// tb/tb_dmem_responder.sv - directed self-checking bench for dmem_responder
module tb_dmem_responder;

    localparam int ADDR_W  = 10;
    localparam int LATENCY = 3;

    logic        clk_i = 1'b0;
    logic        rst_i = 1'b1;
    logic        req_i = 1'b0;
    logic        we_i = 1'b0;
    logic [1:0]  size_i = 2'd0;
    logic        unsigned_i = 1'b0;
    logic [31:0] addr_i = '0;
    logic [31:0] wdata_i = '0;
    logic        ack_o;
    logic [31:0] rdata_o;
    logic        err_o;
    logic        stall_o;

    int checks = 0;
    int errors = 0;

    dmem_responder #(.ADDR_W(ADDR_W), .LATENCY(LATENCY)) dut (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .req_i      (req_i),
        .we_i       (we_i),
        .size_i     (size_i),
        .unsigned_i (unsigned_i),
        .addr_i     (addr_i),
        .wdata_i    (wdata_i),
        .ack_o      (ack_o),
        .rdata_o    (rdata_o),
        .err_o      (err_o),
        .stall_o    (stall_o)
    );

    always #5 clk_i = ~clk_i;

    // Runs one request from an IDLE cycle; returns acceptance-to-ack latency, response and
    // whether stall_o was high in every cycle before the ack and low in the ack cycle.
    // Ends #1 into the cycle after RESP, reporting whether outputs there are all zero.
    task automatic access(input logic we, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd,
                          output int lat, output logic [31:0] rd, output logic er,
                          output bit stall_ok, output bit post_zero);
        we_i = we; size_i = sz; unsigned_i = uns; addr_i = addr; wdata_i = wd; req_i = 1'b1;
        #1;
        stall_ok = (stall_o === 1'b1);
        lat = 0; rd = 'x; er = 1'bx;
        while (lat < 40) begin
            @(posedge clk_i); #1;
            lat++;
            if (ack_o === 1'b1) begin
                rd = rdata_o; er = err_o;
                if (stall_o !== 1'b0) stall_ok = 0;
                break;
            end
            if (stall_o !== 1'b1) stall_ok = 0;
        end
        req_i = 1'b0;
        @(posedge clk_i); #1;
        post_zero = (ack_o === 1'b0) && (rdata_o === 32'd0) && (err_o === 1'b0);
    endtask

    task automatic test_reset();
        rst_i = 1'b1;
        repeat (3) @(posedge clk_i);
        #1;
        checks++;
        if (ack_o !== 1'b0 || rdata_o !== 32'd0 || err_o !== 1'b0 || stall_o !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: ack=%b rdata=%h err=%b stall=%b, required 0/0/0/0",
                     ack_o, rdata_o, err_o, stall_o);
        end
        rst_i = 1'b0;
        @(posedge clk_i); #1;
    endtask

    task automatic test_word();
        int lat; logic [31:0] rd; logic er; bit sok, pz;
        access(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEADBEEF, lat, rd, er, sok, pz);
        checks++;
        if (lat !== LATENCY + 1) begin
            errors++; $display("FAIL sw_latency: got %0d, required %0d", lat, LATENCY + 1);
        end
        checks++;
        if (!sok) begin errors++; $display("FAIL sw_stall: stall pattern wrong, required 1 until ack then 0"); end
        checks++;
        if (er !== 1'b0 || rd !== 32'd0) begin
            errors++; $display("FAIL sw_resp: err=%b rdata=%h, required 0/00000000", er, rd);
        end
        checks++;
        if (!pz) begin errors++; $display("FAIL post_resp_zero: outputs not cleared after RESP, required 0"); end
        access(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, lat, rd, er, sok, pz);
        checks++;
        if (rd !== 32'hDEADBEEF || er !== 1'b0) begin
            errors++; $display("FAIL lw_10: rdata=%h err=%b, required deadbeef/0", rd, er);
        end
        checks++;
        if (!pz) begin errors++; $display("FAIL lw_post_zero: rdata/err not cleared after RESP, required 0"); end
    endtask

    task automatic test_subword();
        int lat; logic [31:0] rd; logic er; bit sok, pz;
        access(1'b1, 2'd0, 1'b0, 32'h11, 32'h00000080, lat, rd, er, sok, pz);
        access(1'b0, 2'd0, 1'b0, 32'h11, 32'h0, lat, rd, er, sok, pz);
        checks++;
        if (rd !== 32'hFFFFFF80) begin errors++; $display("FAIL lb_11: got %h, required ffffff80", rd); end
        access(1'b0, 2'd0, 1'b1, 32'h11, 32'h0, lat, rd, er, sok, pz);
        checks++;
        if (rd !== 32'h00000080) begin errors++; $display("FAIL lbu_11: got %h, required 00000080", rd); end
        access(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, lat, rd, er, sok, pz);
        checks++;
        if (rd !== 32'hDEAD80EF) begin errors++; $display("FAIL lw_after_sb: got %h, required dead80ef", rd); end
        access(1'b0, 2'd1, 1'b0, 32'h12, 32'h0, lat, rd, er, sok, pz);
        checks++;
        if (rd !== 32'hFFFFDEAD || er !== 1'b0) begin
            errors++; $display("FAIL lh_12: rdata=%h err=%b, required ffffdead/0", rd, er);
        end
        access(1'b0, 2'd1, 1'b1, 32'h12, 32'h0, lat, rd, er, sok, pz);
        checks++;
        if (rd !== 32'h0000DEAD) begin errors++; $display("FAIL lhu_12: got %h, required 0000dead", rd); end
        access(1'b1, 2'd1, 1'b0, 32'h12, 32'hAAAA1234, lat, rd, er, sok, pz);
        access(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, lat, rd, er, sok, pz);
        checks++;
        if (rd !== 32'h123480EF) begin errors++; $display("FAIL lw_after_sh: got %h, required 123480ef", rd); end
    endtask

    task automatic test_misaligned();
        int lat; logic [31:0] rd; logic er; bit sok, pz;
        access(1'b0, 2'd1, 1'b0, 32'h13, 32'h0, lat, rd, er, sok, pz);
        checks++;
        if (lat !== LATENCY + 1 || er !== 1'b1 || rd !== 32'd0) begin
            errors++; $display("FAIL lh_misaligned: lat=%0d err=%b rdata=%h, required %0d/1/00000000",
                               lat, er, rd, LATENCY + 1);
        end
        access(1'b1, 2'd2, 1'b0, 32'h12, 32'h12345678, lat, rd, er, sok, pz);
        checks++;
        if (er !== 1'b1) begin errors++; $display("FAIL sw_misaligned: err=%b, required 1", er); end
        checks++;
        if (!pz) begin errors++; $display("FAIL err_post_zero: err not cleared after RESP, required 0"); end
        access(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, lat, rd, er, sok, pz);
        checks++;
        if (rd !== 32'h123480EF) begin errors++; $display("FAIL lw_after_bad_sw: got %h, required 123480ef", rd); end
        access(1'b0, 2'd3, 1'b0, 32'h10, 32'h0, lat, rd, er, sok, pz);
        checks++;
        if (er !== 1'b1 || rd !== 32'd0) begin
            errors++; $display("FAIL size3: err=%b rdata=%h, required 1/00000000", er, rd);
        end
    endtask

    task automatic test_out_of_range();
        int lat; logic [31:0] rd; logic er; bit sok, pz;
        access(1'b1, 2'd2, 1'b0, 32'h0, 32'hA5A50000, lat, rd, er, sok, pz);
        access(1'b1, 2'd2, 1'b0, 32'h00001000, 32'hFFFFFFFF, lat, rd, er, sok, pz);
        checks++;
        if (er !== 1'b1) begin errors++; $display("FAIL oor_sw: err=%b, required 1", er); end
        access(1'b0, 2'd2, 1'b0, 32'h0, 32'h0, lat, rd, er, sok, pz);
        checks++;
        if (rd !== 32'hA5A50000 || er !== 1'b0) begin
            errors++; $display("FAIL lw_0_after_oor: rdata=%h err=%b, required a5a50000/0", rd, er);
        end
        access(1'b0, 2'd2, 1'b0, 32'h00000FFC, 32'h0, lat, rd, er, sok, pz);
        checks++;
        if (er !== 1'b0) begin errors++; $display("FAIL last_word_in_range: err=%b, required 0", er); end
    endtask

    task automatic test_reset_mid_wait();
        int lat; logic [31:0] rd; logic er; bit sok, pz;
        bit saw_ack;
        access(1'b1, 2'd2, 1'b0, 32'h20, 32'h0BADF00D, lat, rd, er, sok, pz);
        we_i = 1'b1; size_i = 2'd2; unsigned_i = 1'b0; addr_i = 32'h20; wdata_i = 32'h11111111;
        req_i = 1'b1;
        @(posedge clk_i); #1;
        @(posedge clk_i); #1;
        rst_i = 1'b1;
        #1;
        checks++;
        if (ack_o !== 1'b0 || rdata_o !== 32'd0 || err_o !== 1'b0) begin
            errors++; $display("FAIL reset_mid_wait: ack=%b rdata=%h err=%b, required 0/0/0", ack_o, rdata_o, err_o);
        end
        req_i = 1'b0;
        saw_ack = 0;
        repeat (LATENCY + 3) begin
            @(posedge clk_i); #1;
            if (ack_o !== 1'b0) saw_ack = 1;
        end
        rst_i = 1'b0;
        repeat (3) begin
            @(posedge clk_i); #1;
            if (ack_o !== 1'b0) saw_ack = 1;
        end
        checks++;
        if (saw_ack) begin errors++; $display("FAIL reset_no_ack: ack seen=1, required 0"); end
        access(1'b0, 2'd2, 1'b0, 32'h20, 32'h0, lat, rd, er, sok, pz);
        checks++;
        if (rd !== 32'h0BADF00D) begin errors++; $display("FAIL lw_20_after_reset: got %h, required 0badf00d", rd); end
    endtask

    task automatic test_back_to_back();
        int acks = 0;
        int first_ack = -1;
        int second_ack = -1;
        bit stall_bad = 0;
        logic [31:0] rd2 = '0;
        we_i = 1'b1; size_i = 2'd2; unsigned_i = 1'b0; addr_i = 32'h30; wdata_i = 32'h01020304;
        req_i = 1'b1;
        #1;
        for (int c = 0; c < 12; c++) begin
            if (ack_o === 1'b1) begin
                acks++;
                if (first_ack < 0) first_ack = c;
                else begin second_ack = c; rd2 = rdata_o; end
            end
            if (c <= 2 * (LATENCY + 2) - 1) begin
                if (stall_o !== !(c == LATENCY + 1 || c == 2 * LATENCY + 3)) stall_bad = 1;
            end else if (stall_o !== 1'b0) stall_bad = 1;
            if (c == LATENCY + 1) begin we_i = 1'b0; wdata_i = 32'h0; end
            if (c == 2 * LATENCY + 3) req_i = 1'b0;
            @(posedge clk_i); #1;
        end
        checks++;
        if (acks !== 2) begin errors++; $display("FAIL b2b_ack_count: got %0d, required 2", acks); end
        checks++;
        if (first_ack !== LATENCY + 1 || second_ack - first_ack !== LATENCY + 2) begin
            errors++; $display("FAIL b2b_spacing: acks at %0d,%0d, required %0d,%0d",
                               first_ack, second_ack, LATENCY + 1, 2 * LATENCY + 3);
        end
        checks++;
        if (stall_bad) begin errors++; $display("FAIL b2b_stall: stall low outside RESP or high after, required low only in RESP"); end
        checks++;
        if (rd2 !== 32'h01020304) begin errors++; $display("FAIL b2b_raw: got %h, required 01020304", rd2); end
    endtask

    initial begin
        test_reset();
        test_word();
        test_subword();
        test_misaligned();
        test_out_of_range();
        test_reset_mid_wait();
        test_back_to_back();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
